id_operand_stage: RTL

Instruction-decode and operand-fetch stage.
- Decodes a 32-bit MIPS instruction from IF.
- Drives the register file's two read ports and resolves RAW hazards, by forwarding or by stalling.
- Registers decoded operands into the ID/EX pipeline register.
- Sits between the IF/ID register and the execute stage; the register file's write port is fed by write-back.

---
 rtl/id_operand_stage_pkg.sv | 40 ++++
 rtl/id_operand_stage_hazard_unit.sv | 63 ++++++
 rtl/id_operand_stage.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_operand_stage_pkg.sv
// ----------------------------------------------------------------------------
// id_operand_stage_pkg
// Shared definitions for the decode / operand-fetch stage: bus widths, MIPS
// opcode values, the ex_op encoding seen by the execute stage and the
// operand forward-select encoding produced by the hazard unit.
// No ports (package).
// ----------------------------------------------------------------------------
package id_operand_stage_pkg;

  localparam int REG_BUS_W  = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

  // Primary opcode field inst[31:26]
  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_ADDIU   = 6'h09;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_SW      = 6'h2B;

  // Operation handed to the execute stage
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_OR    = 3'd1,
    OP_ADDU  = 3'd2,
    OP_LUI   = 3'd3,
    OP_LW    = 3'd4,
    OP_SW    = 3'd5,
    OP_RTYPE = 3'd6
  } ex_op_e;

  // Where a source operand comes from
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_operand_stage_hazard_unit.sv
// ----------------------------------------------------------------------------
// id_hazard_unit
// RAW hazard compare logic for the decode stage.
// Build option FORWARD_EN:
//   defined   - EX/MEM results are forwarded (EX wins over MEM); only a
//               load-use dependency on the ID/EX entry raises o_hazard.
//   undefined - no forwarding; any enabled source matching a pending EX or
//               MEM write (or a load-use) raises o_hazard until the producer
//               reaches write-back, where the register file bypasses it.
// Ports:
//   i_use1/i_use2        source enabled and nonzero (rs / rt)
//   i_rs/i_rt            source register addresses
//   i_ex_we/i_ex_waddr   pending write from EX
//   i_mem_we/i_mem_waddr pending write from MEM
//   i_idex_*             current ID/EX entry (load-use detection)
//   o_sel1/o_sel2        forward select per source
//   o_hazard             stall request
// ----------------------------------------------------------------------------
module id_hazard_unit
  import id_operand_stage_pkg::*;
#(
  parameter int AW = REG_ADDR_W
) (
  input  logic          i_use1,
  input  logic          i_use2,
  input  logic [AW-1:0] i_rs,
  input  logic [AW-1:0] i_rt,
  input  logic          i_ex_we,
  input  logic [AW-1:0] i_ex_waddr,
  input  logic          i_mem_we,
  input  logic [AW-1:0] i_mem_waddr,
  input  logic          i_idex_valid,
  input  logic          i_idex_is_load,
  input  logic          i_idex_we,
  input  logic [AW-1:0] i_idex_waddr,
  output fwd_sel_e      o_sel1,
  output fwd_sel_e      o_sel2,
  output logic          o_hazard
);

  logic w_ex_hit1, w_ex_hit2, w_mem_hit1, w_mem_hit2, w_load_use;

  // i_use* already excludes register 0, so $0 never matches anything.
  assign w_ex_hit1  = i_use1 && i_ex_we  && (i_ex_waddr  == i_rs);
  assign w_ex_hit2  = i_use2 && i_ex_we  && (i_ex_waddr  == i_rt);
  assign w_mem_hit1 = i_use1 && i_mem_we && (i_mem_waddr == i_rs);
  assign w_mem_hit2 = i_use2 && i_mem_we && (i_mem_waddr == i_rt);

  assign w_load_use = i_idex_valid && i_idex_is_load && i_idex_we &&
                      ((i_use1 && (i_idex_waddr == i_rs)) ||
                       (i_use2 && (i_idex_waddr == i_rt)));

`ifdef FORWARD_EN
  assign o_sel1   = w_ex_hit1 ? FWD_EX : (w_mem_hit1 ? FWD_MEM : FWD_RF);
  assign o_sel2   = w_ex_hit2 ? FWD_EX : (w_mem_hit2 ? FWD_MEM : FWD_RF);
  assign o_hazard = w_load_use;
`else
  assign o_sel1   = FWD_RF;
  assign o_sel2   = FWD_RF;
  assign o_hazard = w_load_use || w_ex_hit1 || w_ex_hit2 || w_mem_hit1 || w_mem_hit2;
`endif

endmodule

// File: rtl/id_operand_stage.sv
// ----------------------------------------------------------------------------
// id_operand_stage
// MIPS instruction decode and operand fetch. Decodes if_inst, drives the two
// register-file read ports, resolves RAW hazards (forwarding or stalling via
// id_hazard_unit) and registers the decoded entry into ID/EX.
// Build option FORWARD_EN enables the EX/MEM forwarding muxes.
// Ports:
//   clk, rst (async, active-low)
//   if_valid/if_inst/id_ready           IF handshake: an instruction moves
//       from IF into ID on a rising edge where if_valid && id_ready; IF holds
//       if_inst while id_ready is low.
//   raddr1/re1/rdata1, raddr2/re2/rdata2  register-file read ports (rs, rt)
//   ex_fwd_*, mem_fwd_*                 pending results from EX and MEM
//   ex_stall (freeze ID/EX), flush (bubble ID/EX)
//   ex_*                                ID/EX register outputs
//   stall_cnt                           saturating hazard-stall cycle count
// ----------------------------------------------------------------------------
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DW = REG_BUS_W,
  parameter int AW = REG_ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_valid,
  input  logic [31:0]   if_inst,
  output logic          id_ready,
  output logic [AW-1:0] raddr1,
  output logic          re1,
  input  logic [DW-1:0] rdata1,
  output logic [AW-1:0] raddr2,
  output logic          re2,
  input  logic [DW-1:0] rdata2,
  input  logic          ex_fwd_we,
  input  logic [AW-1:0] ex_fwd_waddr,
  input  logic [DW-1:0] ex_fwd_wdata,
  input  logic          mem_fwd_we,
  input  logic [AW-1:0] mem_fwd_waddr,
  input  logic [DW-1:0] mem_fwd_wdata,
  input  logic          ex_stall,
  input  logic          flush,
  output logic          ex_valid,
  output logic [2:0]    ex_op,
  output logic [5:0]    ex_funct,
  output logic [DW-1:0] ex_src1,
  output logic [DW-1:0] ex_src2,
  output logic [DW-1:0] ex_store_data,
  output logic          ex_we,
  output logic [AW-1:0] ex_waddr,
  output logic          ex_is_load,
  output logic          ex_illegal,
  output logic [31:0]   stall_cnt
);

  // Instruction fields
  logic [5:0]    w_opc;
  logic [AW-1:0] w_rs, w_rt, w_rd;
  logic [15:0]   w_imm;
  logic          w_unused_shamt;

  assign w_opc = if_inst[31:26];
  assign w_rs  = if_inst[25:21];
  assign w_rt  = if_inst[20:16];
  assign w_rd  = if_inst[15:11];
  assign w_imm = if_inst[15:0];
  assign w_unused_shamt = ^if_inst[10:6];

  // Decode
  logic          w_re1, w_re2, w_we, w_is_load, w_illegal;
  logic          w_use_imm, w_is_lui, w_is_store;
  ex_op_e        w_op;
  logic [5:0]    w_funct;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_imm_ext;

  always_comb begin
    w_re1      = 1'b0;
    w_re2      = 1'b0;
    w_we       = 1'b0;
    w_is_load  = 1'b0;
    w_illegal  = 1'b0;
    w_use_imm  = 1'b0;
    w_is_lui   = 1'b0;
    w_is_store = 1'b0;
    w_op       = OP_NOP;
    w_funct    = '0;
    w_waddr    = '0;
    w_imm_ext  = ZERO_WORD;
    case (w_opc)
      OPC_SPECIAL: begin
        w_re1 = 1'b1; w_re2 = 1'b1; w_op = OP_RTYPE;
        w_funct = if_inst[5:0]; w_we = 1'b1; w_waddr = w_rd;
      end
      OPC_ORI: begin
        w_re1 = 1'b1; w_op = OP_OR; w_use_imm = 1'b1;
        w_imm_ext = {{(DW-16){1'b0}}, w_imm}; w_we = 1'b1; w_waddr = w_rt;
      end
      OPC_ADDIU: begin
        w_re1 = 1'b1; w_op = OP_ADDU; w_use_imm = 1'b1;
        w_imm_ext = {{(DW-16){w_imm[15]}}, w_imm}; w_we = 1'b1; w_waddr = w_rt;
      end
      OPC_LUI: begin
        // src2 is the zero default of w_imm_ext
        w_op = OP_LUI; w_is_lui = 1'b1; w_use_imm = 1'b1;
        w_we = 1'b1; w_waddr = w_rt;
      end
      OPC_LW: begin
        w_re1 = 1'b1; w_op = OP_LW; w_use_imm = 1'b1; w_is_load = 1'b1;
        w_imm_ext = {{(DW-16){w_imm[15]}}, w_imm}; w_we = 1'b1; w_waddr = w_rt;
      end
      OPC_SW: begin
        w_re1 = 1'b1; w_re2 = 1'b1; w_op = OP_SW; w_use_imm = 1'b1;
        w_is_store = 1'b1; w_imm_ext = {{(DW-16){w_imm[15]}}, w_imm};
      end
      default: w_illegal = 1'b1;
    endcase
    if (!if_valid) begin
      w_re1 = 1'b0;
      w_re2 = 1'b0;
    end
    if (w_waddr == '0) w_we = 1'b0;
  end

  assign raddr1 = w_rs;
  assign raddr2 = w_rt;
  assign re1    = w_re1;
  assign re2    = w_re2;

  // Sources reading $0 are constant zero and never take part in hazards.
  logic w_use1, w_use2, w_hazard;
  fwd_sel_e w_sel1, w_sel2;

  assign w_use1 = w_re1 && (w_rs != '0);
  assign w_use2 = w_re2 && (w_rt != '0);

  id_hazard_unit #(.AW(AW)) u_hazard (
    .i_use1         (w_use1),
    .i_use2         (w_use2),
    .i_rs           (w_rs),
    .i_rt           (w_rt),
    .i_ex_we        (ex_fwd_we),
    .i_ex_waddr     (ex_fwd_waddr),
    .i_mem_we       (mem_fwd_we),
    .i_mem_waddr    (mem_fwd_waddr),
    .i_idex_valid   (ex_valid),
    .i_idex_is_load (ex_is_load),
    .i_idex_we      (ex_we),
    .i_idex_waddr   (ex_waddr),
    .o_sel1         (w_sel1),
    .o_sel2         (w_sel2),
    .o_hazard       (w_hazard)
  );

  // Operand muxes
  logic [DW-1:0] w_opnd1, w_opnd2, w_src1, w_src2, w_store;

  always_comb begin
    w_opnd1 = ZERO_WORD;
    if (w_use1) begin
      case (w_sel1)
        FWD_EX:  w_opnd1 = ex_fwd_wdata;
        FWD_MEM: w_opnd1 = mem_fwd_wdata;
        default: w_opnd1 = rdata1;
      endcase
    end
  end

  always_comb begin
    w_opnd2 = ZERO_WORD;
    if (w_use2) begin
      case (w_sel2)
        FWD_EX:  w_opnd2 = ex_fwd_wdata;
        FWD_MEM: w_opnd2 = mem_fwd_wdata;
        default: w_opnd2 = rdata2;
      endcase
    end
  end

  assign w_src1  = w_is_lui ? {w_imm, {(DW-16){1'b0}}} : w_opnd1;
  assign w_src2  = w_use_imm ? w_imm_ext : w_opnd2;
  assign w_store = w_is_store ? w_opnd2 : ZERO_WORD;

  // flush overrides everything, including ex_stall; IF drops its own copy.
  assign id_ready = flush || (!w_hazard && !ex_stall);

  // ID/EX updates unless frozen by ex_stall (flush still bubbles it).
  // Anything other than an accepted instruction writes an all-zero bubble.
  logic w_upd, w_load;
  assign w_upd  = flush || !ex_stall;
  assign w_load = !flush && !ex_stall && !w_hazard && if_valid;

  ex_op_e r_op;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid      <= 1'b0;
      r_op          <= OP_NOP;
      ex_funct      <= '0;
      ex_src1       <= ZERO_WORD;
      ex_src2       <= ZERO_WORD;
      ex_store_data <= ZERO_WORD;
      ex_we         <= 1'b0;
      ex_waddr      <= '0;
      ex_is_load    <= 1'b0;
      ex_illegal    <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      if (w_upd) begin
        ex_valid      <= w_load;
        r_op          <= w_load ? w_op : OP_NOP;
        ex_funct      <= w_load ? w_funct : 6'd0;
        ex_src1       <= w_load ? w_src1 : ZERO_WORD;
        ex_src2       <= w_load ? w_src2 : ZERO_WORD;
        ex_store_data <= w_load ? w_store : ZERO_WORD;
        ex_we         <= w_load && w_we;
        ex_waddr      <= w_load ? w_waddr : '0;
        ex_is_load    <= w_load && w_is_load;
        ex_illegal    <= w_load && w_illegal;
      end
      if (!flush && !ex_stall && w_hazard && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign ex_op = r_op;

endmodule
